// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline hazard logic: forwarding selects,
// result-source encodings and the data-memory wait FSM states.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_ERR
  } mem_state_t;

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Data-memory wait tracker: freezes the pipe while dmem is busy and escalates
// to a sticky error after MEM_TIMEOUT consecutive wait cycles.
module hazard_mem_wait_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic dmem_ready,
  output logic mem_stall,
  output logic err_freeze,
  output logic mem_err
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // wcnt counts wait cycles already spent; the IDLE cycle that starts a wait is cycle 1.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      MEM_IDLE: begin
        if (mem_req && !dmem_ready) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || !mem_req) begin
          state_d = MEM_IDLE;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = MEM_ERR;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      MEM_ERR:  state_d = MEM_ERR;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_stall  = (state_q == MEM_IDLE || state_q == MEM_WAIT) && mem_req && !dmem_ready;
    err_freeze = (state_q == MEM_ERR);
    mem_err    = err_q;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: E-stage forwarding,
// load-use stalls, branch flushes, dmem freeze and saturating debug counters.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  dmem_ready,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic mem_stall;
  logic err_freeze;
  logic lw_stall;
  logic any_stall;
  logic branch_flush;

  hazard_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (MemReqM),
    .dmem_ready (dmem_ready),
    .mem_stall  (mem_stall),
    .err_freeze (err_freeze),
    .mem_err    (mem_err)
  );

  // x0 is never forwarded; the M-stage result is younger and wins over W.
  function automatic fwd_sel_t fwd_pick(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_m,
    input logic                  we_w
  );
    if (we_m && rd_m != '0 && rd_m == rs) return FWD_MEM;
    if (we_w && rd_w != '0 && rd_w == rs) return FWD_WB;
    return FWD_RF;
  endfunction

  assign ForwardAE = fwd_pick(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
  assign ForwardBE = fwd_pick(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  // A frozen pipe holds a resolved branch in E, so its flush is deferred until release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (err_freeze || mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign any_stall    = StallF || StallD || StallE || StallM;
  assign branch_flush = PCSrcE && !mem_stall && !err_freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (any_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 6;
  localparam int unsigned TO   = 16;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic          mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (AW),
    .CNT_W      (CW),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Reference model: error flag, consecutive-wait count and plain integer counters.
  bit          m_err   = 1'b0;
  int unsigned m_n     = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  logic        m_freeze, m_lu;
  logic [3:0]  exp_stall;
  logic [2:0]  exp_flush;
  logic [10:0] exp_ctl, act_ctl;

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs, rdm, rdw,
                                         input logic wm, ww);
    if (rs == '0) return 2'b00;
    if (wm && rdm == rs) return 2'b10;
    if (ww && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  assign m_freeze = m_err || (MemReqM && !dmem_ready);
  assign m_lu     = (ResultSrcE == 2'b01) && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);

  always_comb begin
    exp_stall = 4'b0000;
    exp_flush = 3'b000;
    if (m_freeze) begin
      exp_stall = 4'b1111;
      exp_flush = 3'b001;
    end else if (PCSrcE) begin
      exp_flush = 3'b110;
    end else if (m_lu) begin
      exp_stall = 4'b1100;
      exp_flush = 3'b010;
    end
  end

  assign exp_ctl = {fwd_ref(Rs1E, RdM, RdW, RegWriteM, RegWriteW),
                    fwd_ref(Rs2E, RdM, RdW, RegWriteM, RegWriteW), exp_stall, exp_flush};
  assign act_ctl = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  always @(posedge clk) begin
    if (reset) begin
      m_err   <= 1'b0;
      m_n     <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (exp_stall != 4'b0000 && m_stall < CMAX) m_stall <= m_stall + 1;
      if (PCSrcE && !m_freeze && m_flush < CMAX) m_flush <= m_flush + 1;
      if (!m_err) begin
        if (MemReqM && !dmem_ready) begin
          m_n <= m_n + 1;
          if (m_n + 1 == TO) m_err <= 1'b1;
        end else begin
          m_n <= 0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; MemReqM = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    compared++;
    if (stall_cnt !== '0) begin mismatched++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    compared++;
    if (flush_cnt !== '0) begin mismatched++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
    compared++;
    if (mem_err !== 1'b0) begin mismatched++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
    compared++;
    if (act_ctl !== 11'b0) begin mismatched++; $display("FAIL reset_ctl: got %b expected %b", act_ctl, 11'b0); end
  endtask

  task automatic test_forwarding();
    do_reset();
    RdM = AW'(5); RegWriteM = 1'b1; Rs1E = AW'(5); RdW = AW'(5); RegWriteW = 1'b1;
    #1;
    compared++;
    if (ForwardAE !== 2'b10) begin mismatched++; $display("FAIL fwd_m_wins: got %b expected 10", ForwardAE); end
    RdM = '0;
    #1;
    compared++;
    if (ForwardAE !== 2'b01) begin mismatched++; $display("FAIL fwd_w_when_rdm0: got %b expected 01", ForwardAE); end
    Rs2E = AW'(5); RegWriteW = 1'b0;
    #1;
    compared++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      mismatched++; $display("FAIL fwd_none: got %b expected 0000", {ForwardAE, ForwardBE});
    end
    RdM = AW'(5); RegWriteM = 1'b1; Rs1E = '0;
    #1;
    compared++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin
      mismatched++; $display("FAIL fwd_b_m_x0a: got %b expected 0010", {ForwardAE, ForwardBE});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ResultSrcE = 2'b01; RdE = AW'(7); Rs2D = AW'(7);
    #1;
    compared++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1100010) begin
      mismatched++;
      $display("FAIL lw_stall: got %b expected 1100010", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    next_cycle();
    RdE = '0; Rs2D = '0;
    #1;
    compared++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      mismatched++; $display("FAIL lw_rd0: got %b expected 000", {StallF, StallD, FlushE});
    end
    RdE = AW'(9); Rs1D = AW'(9); PCSrcE = 1'b1;
    #1;
    compared++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      mismatched++; $display("FAIL branch_over_lw: got %b expected 0011", {StallF, StallD, FlushD, FlushE});
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    #1;
    compared++;
    if (flush_cnt !== '0) begin mismatched++; $display("FAIL br_cnt_start: got %0d expected 0", flush_cnt); end
    PCSrcE = 1'b1;
    #1;
    compared++;
    if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
      mismatched++; $display("FAIL br_flush: got %b expected 1100", {FlushD, FlushE, StallF, StallD});
    end
    next_cycle();
    PCSrcE = 1'b0;
    #1;
    compared++;
    if (flush_cnt !== CW'(1)) begin mismatched++; $display("FAIL br_cnt_one: got %0d expected 1", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReqM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1111001) begin
        mismatched++;
        $display("FAIL mw_freeze%0d: got %b expected 1111001", i,
                 {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
      end
      next_cycle();
    end
    dmem_ready = 1'b1;
    #1;
    compared++;
    if ({StallF, StallM, FlushW} !== 3'b000) begin
      mismatched++; $display("FAIL mw_release: got %b expected 000", {StallF, StallM, FlushW});
    end
    next_cycle();
    MemReqM = 1'b0; dmem_ready = 1'b0;
    #1;
    compared++;
    if (stall_cnt !== CW'(3)) begin mismatched++; $display("FAIL mw_stall_cnt: got %0d expected 3", stall_cnt); end
    MemReqM = 1'b1; dmem_ready = 1'b1;
    #1;
    compared++;
    if ({StallF, StallM, FlushW} !== 3'b000) begin
      mismatched++; $display("FAIL mw_ready_same_cycle: got %b expected 000", {StallF, StallM, FlushW});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    MemReqM = 1'b1; dmem_ready = 1'b0;
    repeat (TO - 1) next_cycle();
    dmem_ready = 1'b1;
    next_cycle();
    MemReqM = 1'b0;
    #1;
    compared++;
    if (mem_err !== 1'b0) begin mismatched++; $display("FAIL to_just_under: got %b expected 0", mem_err); end
    next_cycle();
    MemReqM = 1'b1; dmem_ready = 1'b0;
    repeat (TO) next_cycle();
    MemReqM = 1'b0; dmem_ready = 1'b1; PCSrcE = 1'b1;
    #1;
    compared++;
    if (mem_err !== 1'b1) begin mismatched++; $display("FAIL to_err_set: got %b expected 1", mem_err); end
    compared++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1111001) begin
      mismatched++;
      $display("FAIL to_freeze_persists: got %b expected 1111001",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    end
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    compared++;
    if ({mem_err, stall_cnt, flush_cnt} !== '0) begin
      mismatched++;
      $display("FAIL to_reset_clears: got err=%b stall=%0d flush=%0d expected all 0", mem_err, stall_cnt, flush_cnt);
    end
    compared++;
    if (act_ctl !== 11'b0) begin mismatched++; $display("FAIL to_reset_idle: got %b expected 0", act_ctl); end
  endtask

  task automatic test_branch_during_wait();
    do_reset();
    PCSrcE = 1'b1; MemReqM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      compared++;
      if ({FlushD, FlushE, StallF, StallE} !== 4'b0011) begin
        mismatched++; $display("FAIL bw_held%0d: got %b expected 0011", i, {FlushD, FlushE, StallF, StallE});
      end
      next_cycle();
    end
    dmem_ready = 1'b1;
    #1;
    compared++;
    if ({FlushD, FlushE, StallF, StallE} !== 4'b1100) begin
      mismatched++; $display("FAIL bw_release: got %b expected 1100", {FlushD, FlushE, StallF, StallE});
    end
    next_cycle();
    PCSrcE = 1'b0; MemReqM = 1'b0;
    #1;
    compared++;
    if (flush_cnt !== CW'(1)) begin mismatched++; $display("FAIL bw_flush_cnt: got %0d expected 1", flush_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    ResultSrcE = 2'b01; RdE = AW'(3); Rs1D = AW'(3);
    repeat (CMAX + 5) next_cycle();
    compared++;
    if (stall_cnt !== CW'(CMAX)) begin
      mismatched++; $display("FAIL sat_stall: got %0d expected %0d", stall_cnt, CMAX);
    end
    PCSrcE = 1'b1;
    repeat (CMAX + 5) next_cycle();
    compared++;
    if ({stall_cnt, flush_cnt} !== {CW'(CMAX), CW'(CMAX)}) begin
      mismatched++; $display("FAIL sat_flush: got stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt, CMAX, CMAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 450; i++) begin
      next_cycle();
      Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
      Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
      RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
      RdW  = AW'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = 1'($urandom_range(0, 1));
      dmem_ready = ($urandom_range(0, 2) != 0);
      reset      = ($urandom_range(0, 79) == 0);
      if ((i % 150) >= 100 && (i % 150) < 100 + TO + 2) begin
        MemReqM = 1'b1; dmem_ready = 1'b0; reset = 1'b0;
      end
      if ((i % 150) == 130) reset = 1'b1;
      #1;
      compared++;
      if (act_ctl !== exp_ctl) begin
        mismatched++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, act_ctl, exp_ctl);
      end
      compared++;
      if ({mem_err, stall_cnt, flush_cnt} !== {m_err, CW'(m_stall), CW'(m_flush)}) begin
        mismatched++;
        $display("FAIL rnd_state[%0d]: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 i, mem_err, stall_cnt, flush_cnt, m_err, m_stall, m_flush);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_flush();
    test_mem_wait();
    test_timeout();
    test_branch_during_wait();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
